// File: rtl/tick_gen_if.sv
// tick_gen_if: tick_gen register-write port (wr_en/wr_chan/wr_op/wr_data) and per-channel tick/toggle/busy outputs
interface tick_gen_if #(
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 16
);
  logic                 wr_en;
  logic [2:0]           wr_chan;
  logic [1:0]           wr_op;
  logic [CNT_WIDTH-1:0] wr_data;
  logic [CHANNELS-1:0]  tick;
  logic [CHANNELS-1:0]  toggle;
  logic [CHANNELS-1:0]  busy;
  modport master (output wr_en, wr_chan, wr_op, wr_data, input tick, toggle, busy);
  modport slave  (input wr_en, wr_chan, wr_op, wr_data, output tick, toggle, busy);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: N runtime-programmable divider channels; ports clock, reset (sync, active-high), bus (write port in, tick/toggle/busy out)
module tick_gen #(
  parameter int                            CHANNELS  = 2,
  parameter int                            CNT_WIDTH = 16,
  parameter logic [CHANNELS*CNT_WIDTH-1:0] DEF_DIV   = {16'd380, 16'd216},
  parameter logic [CHANNELS-1:0]           DEF_EN    = 2'b11
) (
  input logic       clock,
  input logic       reset,
  tick_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PERIODIC, ONESHOT} mode_e;
  localparam logic [1:0] OP_SET = 2'd0, OP_PER = 2'd1, OP_STOP = 2'd2, OP_ONE = 2'd3;
  logic [CHANNELS-1:0] tick_v, tog_v, busy_v;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mode_e                mode_q, mode_d;
    logic [CNT_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
    logic                 tick_q, tick_d, tog_q, tog_d, sel;
    assign sel = bus.wr_en && bus.wr_chan == 3'(c);
    always_ff @(posedge clock) begin
      if (reset) begin
        div_q  <= DEF_DIV[c*CNT_WIDTH +: CNT_WIDTH];
        cnt_q  <= DEF_DIV[c*CNT_WIDTH +: CNT_WIDTH];
        mode_q <= DEF_EN[c] ? PERIODIC : IDLE;
        tick_q <= 1'b0;
        tog_q  <= 1'b0;
      end else begin
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        mode_q <= mode_d;
        tick_q <= tick_d;
        tog_q  <= tog_d;
      end
    end
    // div_d doubles as the reload value so a divisor write on a terminal edge is forwarded
    always_comb begin
      div_d  = (sel && bus.wr_op == OP_SET) ? bus.wr_data : div_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      tick_d = 1'b0;
      tog_d  = tog_q;
      if (sel && (bus.wr_op == OP_PER || bus.wr_op == OP_ONE)) begin
        cnt_d  = div_q;
        mode_d = bus.wr_op == OP_ONE ? ONESHOT : PERIODIC;
      end else if (sel && bus.wr_op == OP_STOP) begin
        mode_d = IDLE;
      end else if (mode_q != IDLE && cnt_q == '0) begin
        cnt_d  = div_d;
        tick_d = 1'b1;
        tog_d  = ~tog_q;
        mode_d = mode_q == ONESHOT ? IDLE : mode_q;
      end else if (mode_q != IDLE) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end
    assign tick_v[c] = tick_q;
    assign tog_v[c]  = tog_q;
    assign busy_v[c] = mode_q != IDLE;
  end
  assign bus.tick   = tick_v;
  assign bus.toggle = tog_v;
  assign bus.busy   = busy_v;
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: randomized and directed checks of tick_gen against a timestamp-based reference model
module tb_tick_gen;
  localparam int CH = 2;
  logic clock = 1'b0, reset = 1'b1;
  tick_gen_if #(.CHANNELS(CH), .CNT_WIDTH(16)) bus ();
  tick_gen dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int tests = 0, fails = 0;
  longint n = 0;
  int     def_div[CH] = '{216, 380};
  bit     def_en[CH]  = '{1'b1, 1'b1};
  int     m_div[CH];
  int     m_mode[CH];
  longint m_nt[CH];
  bit     m_tick[CH], m_tog[CH];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask
  // mode: 0 idle, 1 periodic, 2 one-shot; m_nt is the absolute edge of the next tick
  task automatic model(bit r, bit e, int ch, int op, int d);
    for (int c = 0; c < CH; c++) begin
      bit sel, due;
      if (r) begin
        m_div[c] = def_div[c]; m_mode[c] = def_en[c] ? 1 : 0;
        m_nt[c] = n + def_div[c] + 1; m_tick[c] = 0; m_tog[c] = 0;
        continue;
      end
      sel = e && ch == c;
      due = m_mode[c] != 0 && n == m_nt[c];
      m_tick[c] = 0;
      if (sel && (op == 1 || op == 3)) begin
        m_mode[c] = op == 3 ? 2 : 1;
        m_nt[c] = n + m_div[c] + 1;
      end else if (sel && op == 2) begin
        m_mode[c] = 0;
      end else if (due) begin
        m_tick[c] = 1;
        m_tog[c] = ~m_tog[c];
        m_nt[c] = n + ((sel && op == 0) ? d : m_div[c]) + 1;
        if (m_mode[c] == 2) m_mode[c] = 0;
      end
      if (sel && op == 0) m_div[c] = d;
    end
  endtask
  task automatic step(bit r, bit e, int ch, int op, int d);
    logic [CH-1:0] et, eg, eb;
    reset = r; bus.wr_en = e; bus.wr_chan = 3'(ch); bus.wr_op = 2'(op); bus.wr_data = 16'(d);
    @(posedge clock);
    n++;
    model(r, e, ch, op, d);
    #1;
    for (int c = 0; c < CH; c++) begin
      et[c] = m_tick[c]; eg[c] = m_tog[c]; eb[c] = m_mode[c] != 0;
    end
    check("tick", 32'(bus.tick), 32'(et));
    check("toggle", 32'(bus.toggle), 32'(eg));
    check("busy", 32'(bus.busy), 32'(eb));
    reset = 1'b0; bus.wr_en = 1'b0;
  endtask
  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic wait_term(int ch);
    for (int i = 0; i < 1000 && !(m_mode[ch] != 0 && m_nt[ch] == n + 1); i++) step(0, 0, 0, 0, 0);
    if (!(m_mode[ch] != 0 && m_nt[ch] == n + 1)) check("wait_term", 0, 1);
  endtask
  initial begin
    bus.wr_en = 1'b0; bus.wr_chan = '0; bus.wr_op = '0; bus.wr_data = '0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 5);
    idle(800);
    for (int i = 0; i < 1000 && !(m_nt[0] == n + 101); i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 9);
    idle(150);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 0, 4);
    step(0, 1, 1, 3, 0);
    idle(55);
    wait_term(0);
    step(0, 1, 0, 2, 0);
    idle(5);
    step(0, 1, 0, 1, 0);
    wait_term(0);
    step(0, 1, 0, 0, 3);
    idle(20);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    idle(10);
    for (int op = 0; op < 4; op++) step(0, 1, 5, op, 7);
    idle(5);
    step(0, 1, 0, 0, 216);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    idle(60);
    step(1, 1, 1, 2, 0);
    idle(400);
    for (int i = 0; i < 3000; i++) begin
      bit r = $urandom_range(0, 299) == 0;
      bit e = $urandom_range(0, 7) == 0;
      int ch = $urandom_range(0, 7) == 0 ? 5 : int'($urandom_range(0, 1));
      step(r, e, ch, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
